// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/response and byte-RAM signals of the memory port arbiter
// master is the arbiter side (it drives the RAM); slave is the core/RAM environment side.
interface mem_port_arbiter_if;
  logic        rdy;
  logic        clear;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ld_req;
  logic        st_req;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    input  rdy, clear, if_req, if_addr, ld_req, st_req, ls_addr, ls_size, ls_wdata,
           mem_din, io_buffer_full,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    output rdy, clear, if_req, if_addr, ld_req, st_req, ls_addr, ls_size, ls_wdata,
           mem_din, io_buffer_full,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one byte-wide RAM port between instruction fetch and load/store
// Transfers are serialised one byte per cycle, little-endian, with a one-cycle idle gap after each done.
module mem_port_arbiter (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [1:0]  r_n;
  logic        r_last_ls;
  logic        r_is_fetch;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_mem_wr;
  logic        r_if_done;
  logic        r_ls_done;
  logic [31:0] r_if_data;
  logic [31:0] r_ls_rdata;

  logic        w_uart_blocked;
  logic        w_st_ok;
  logic        w_can_grant;
  logic        w_fetch_pri;
  logic        w_grant_st;
  logic        w_grant_ld;
  logic        w_grant_if;
  logic [1:0]  w_size_n;
  logic [1:0]  w_lane_next;
  logic [31:0] w_next_a;
  logic [7:0]  w_next_byte;
  logic [31:0] w_buf_next;

  // The UART data/status words must not be written while its buffer is full.
  assign w_uart_blocked = bus.io_buffer_full &&
                          ((bus.ls_addr == 32'h0003_0000) || (bus.ls_addr == 32'h0003_0004));
  assign w_st_ok        = bus.st_req && !w_uart_blocked;
  assign w_can_grant    = !bus.clear && !r_if_done && !r_ls_done;
  assign w_fetch_pri    = r_last_ls && bus.if_req;
  assign w_grant_st     = w_can_grant && !w_fetch_pri && w_st_ok;
  assign w_grant_ld     = w_can_grant && !w_fetch_pri && !w_st_ok && bus.ld_req;
  assign w_grant_if     = w_can_grant && bus.if_req && (w_fetch_pri || (!w_st_ok && !bus.ld_req));

  always_comb begin
    case (bus.ls_size)
      2'd0:    w_size_n = 2'd0;
      2'd1:    w_size_n = 2'd1;
      default: w_size_n = 2'd3;
    endcase
  end

  assign w_lane_next = r_cnt + 2'd1;
  assign w_next_a    = r_addr + 32'(r_cnt) + 32'd1;
  assign w_next_byte = r_wdata[{w_lane_next, 3'b000} +: 8];

  always_comb begin
    w_buf_next                      = r_buf;
    w_buf_next[{r_cnt, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_n        <= 2'd0;
      r_last_ls  <= 1'b0;
      r_is_fetch <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_buf      <= 32'd0;
      r_mem_a    <= 32'd0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_if_data  <= 32'd0;
      r_ls_rdata <= 32'd0;
    end else if (bus.rdy) begin
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_st) begin
            r_state    <= S_WRITE;
            r_addr     <= bus.ls_addr;
            r_mem_a    <= bus.ls_addr;
            r_wdata    <= bus.ls_wdata;
            r_mem_dout <= bus.ls_wdata[7:0];
            r_mem_wr   <= 1'b1;
            r_cnt      <= 2'd0;
            r_n        <= w_size_n;
            r_last_ls  <= 1'b1;
          end else if (w_grant_ld || w_grant_if) begin
            r_state    <= S_READ;
            r_is_fetch <= w_grant_if;
            r_addr     <= w_grant_if ? bus.if_addr : bus.ls_addr;
            r_mem_a    <= w_grant_if ? bus.if_addr : bus.ls_addr;
            r_mem_wr   <= 1'b0;
            r_cnt      <= 2'd0;
            r_n        <= w_grant_if ? 2'd3 : w_size_n;
            r_buf      <= 32'd0;
            r_last_ls  <= w_grant_ld;
          end
        end
        S_READ: begin
          if (bus.clear) begin
            r_state <= S_IDLE;
          end else begin
            r_buf <= w_buf_next;
            if (r_cnt < r_n) begin
              r_mem_a <= w_next_a;
              r_cnt   <= r_cnt + 2'd1;
            end else begin
              r_state <= S_IDLE;
              if (r_is_fetch) begin
                r_if_done <= 1'b1;
                r_if_data <= w_buf_next;
              end else begin
                r_ls_done  <= 1'b1;
                r_ls_rdata <= w_buf_next;
              end
            end
          end
        end
        S_WRITE: begin
          // A store has already been committed, so a flush does not stop it.
          if (r_cnt < r_n) begin
            r_mem_a    <= w_next_a;
            r_mem_dout <= w_next_byte;
            r_cnt      <= r_cnt + 2'd1;
          end else begin
            r_mem_wr  <= 1'b0;
            r_state   <= S_IDLE;
            r_ls_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_a    = r_mem_a;
  assign bus.mem_dout = r_mem_dout;
  assign bus.mem_wr   = r_mem_wr;
  assign bus.if_done  = r_if_done;
  assign bus.if_data  = r_if_data;
  assign bus.ls_done  = r_ls_done;
  assign bus.ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter with a transaction-level model
module tb_mem_port_arbiter;

  localparam logic [1:0] K_FETCH = 2'd1;
  localparam logic [1:0] K_LOAD  = 2'd2;
  localparam logic [1:0] K_STORE = 2'd3;

  typedef struct packed {
    logic        active;
    logic [1:0]  kind;
    logic [2:0]  k;
    logic [2:0]  bytes;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  done;
    logic [31:0] data;
    logic        last_ls;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic cmp_en = 1'b0;
  model_t m;
  logic [31:0] a_log [0:15];

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'h0000_0200: return 8'hAA;
      32'h0000_0201: return 8'hBB;
      32'hFFFF_FFFF: return 8'h5A;
      32'h0000_0000: return 8'hC3;
      default:       return a[7:0] ^ a[15:8] ^ 8'h96;
    endcase
  endfunction

  assign bus.mem_din = rom(bus.mem_a);

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    return (s == 2'd0) ? 3'd1 : (s == 2'd1) ? 3'd2 : 3'd4;
  endfunction

  function automatic logic [31:0] gather(input logic [31:0] a, input logic [2:0] nb);
    logic [31:0] d;
    d = 32'd0;
    for (int i = 0; i < 4; i++)
      if (i < int'(nb)) d[8*i +: 8] = rom(a + 32'(i));
    return d;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [2:0] k);
    logic [31:0] s;
    s = w >> (8 * int'(k));
    return s[7:0];
  endfunction

  // Transfer view: a granted access of b bytes shows address a+k in its k-th cycle and
  // reports done once b edges have elapsed; a done cycle is always followed by an idle one.
  function automatic model_t step(input model_t cur);
    model_t n;
    logic st_ok;
    logic [1:0] g;
    n = cur;
    g = 2'd0;
    if (!bus.rdy) return cur;
    if (cur.done != 2'd0) begin
      n.done = 2'd0;
    end else if (!cur.active) begin
      if (!bus.clear) begin
        st_ok = bus.st_req && !(bus.io_buffer_full &&
                (bus.ls_addr == 32'h30000 || bus.ls_addr == 32'h30004));
        if (cur.last_ls && bus.if_req) g = K_FETCH;
        else if (st_ok)                g = K_STORE;
        else if (bus.ld_req)           g = K_LOAD;
        else if (bus.if_req)           g = K_FETCH;
      end
      if (g != 2'd0) begin
        n.active  = 1'b1;
        n.kind    = g;
        n.k       = 3'd0;
        n.addr    = (g == K_FETCH) ? bus.if_addr : bus.ls_addr;
        n.bytes   = (g == K_FETCH) ? 3'd4 : size_bytes(bus.ls_size);
        n.wdata   = bus.ls_wdata;
        n.last_ls = (g != K_FETCH);
      end
    end else begin
      n.k = cur.k + 3'd1;
      if (cur.kind != K_STORE && bus.clear) begin
        n.active = 1'b0;
      end else if (n.k == cur.bytes) begin
        n.active = 1'b0;
        n.done   = cur.kind;
        n.data   = (cur.kind == K_STORE) ? 32'd0 : gather(cur.addr, cur.bytes);
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) m <= '0;
    else     m <= step(m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("if_done", 32'(bus.if_done), 32'(m.done == K_FETCH));
      check("ls_done", 32'(bus.ls_done), 32'(m.done == K_LOAD || m.done == K_STORE));
      if (m.done == K_FETCH) check("if_data", bus.if_data, m.data);
      if (m.done == K_LOAD)  check("ls_rdata", bus.ls_rdata, m.data);
      check("mem_wr", 32'(bus.mem_wr), 32'(m.active && m.kind == K_STORE));
      if (m.active) check("mem_a", bus.mem_a, m.addr + 32'(m.k));
      if (m.active && m.kind == K_STORE)
        check("mem_dout", 32'(bus.mem_dout), 32'(byte_of(m.wdata, m.k)));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input int clear_at, input bit drop,
                           input int stall_at, output int lat, output int wr,
                           output logic [31:0] data);
    bit found;
    found = 1'b0;
    lat   = -1;
    wr    = 0;
    data  = 32'd0;
    if (clear_at == 0) bus.clear = 1'b1;
    for (int i = 1; i <= budget && !found; i++) begin
      @(negedge clk);
      if (i < 16) a_log[i] = bus.mem_a;
      if (bus.mem_wr) wr++;
      if (bus.if_done || bus.ls_done) begin
        found = 1'b1;
        lat   = i;
        data  = bus.if_done ? bus.if_data : bus.ls_rdata;
      end else begin
        #1;
        bus.clear = (i == clear_at);
        if (i == clear_at && drop) begin
          bus.if_req = 1'b0;
          bus.ld_req = 1'b0;
        end
        if (i == stall_at) bus.rdy = 1'b0;
        if (stall_at > 0 && i == stall_at + 3) bus.rdy = 1'b1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, wr, cnt;
    logic [31:0] d;
    bus.rdy = 1'b1; bus.clear = 1'b0; bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.ld_req = 1'b0; bus.st_req = 1'b0; bus.ls_addr = 32'd0; bus.ls_size = 2'd0;
    bus.ls_wdata = 32'd0; bus.io_buffer_full = 1'b0;
    for (int i = 0; i < 16; i++) a_log[i] = 32'd0;

    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_if_done", 32'(bus.if_done), 32'd0);
    check("rst_ls_done", 32'(bus.ls_done), 32'd0);
    check("rst_if_data", bus.if_data, 32'd0);
    check("rst_ls_rdata", bus.ls_rdata, 32'd0);
    #1 rst = 1'b0;
    idle(1);

    // word fetch, then a done pulse stretched by rdy=0
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    wait_done(12, -1, 1'b0, -1, lat, wr, d);
    check("fetch_lat", 32'(lat), 32'd5);
    check("fetch_data", d, 32'h4433_2211);
    for (int i = 1; i <= 4; i++) check("fetch_addr", a_log[i], 32'h100 + 32'(i - 1));
    #1 bus.if_req = 1'b0; bus.rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("done_hold", 32'(bus.if_done), 32'd1);
    end
    #1 bus.rdy = 1'b1;
    @(negedge clk);
    check("done_drop", 32'(bus.if_done), 32'd0);
    #1;

    // load and fetch together after a fetch: load first, then fetch wins over a new load
    bus.ld_req = 1'b1; bus.ls_addr = 32'h200; bus.ls_size = 2'd1;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    wait_done(12, -1, 1'b0, -1, lat, wr, d);
    check("ld_lat", 32'(lat), 32'd3);
    check("ld_data", d, 32'h0000_BBAA);
    #1 bus.ls_addr = 32'h202; bus.ls_size = 2'd0;
    wait_done(12, -1, 1'b0, -1, lat, wr, d);
    check("fetch_after_ls_lat", 32'(lat), 32'd6);
    check("fetch_after_ls_data", d, 32'h4433_2211);
    #1 bus.if_req = 1'b0;
    wait_done(12, -1, 1'b0, -1, lat, wr, d);
    check("ld2_lat", 32'(lat), 32'd3);
    check("ld2_data", d, 32'h0000_0096);
    #1 bus.ld_req = 1'b0;
    idle(1);

    // UART back-pressure
    bus.st_req = 1'b1; bus.ls_addr = 32'h30000; bus.ls_size = 2'd0;
    bus.ls_wdata = 32'h0000_00A5; bus.io_buffer_full = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_wr) cnt++;
    end
    check("uart_blocked_wr", 32'(cnt), 32'd0);
    #1 bus.io_buffer_full = 1'b0;
    wait_done(12, -1, 1'b0, -1, lat, wr, d);
    check("uart_lat", 32'(lat), 32'd2);
    check("uart_wr_cycles", 32'(wr), 32'd1);
    check("uart_addr", a_log[1], 32'h30000);
    #1 bus.st_req = 1'b0;
    idle(1);

    // clear during a word fetch at cnt=2
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    wait_done(10, 3, 1'b1, -1, lat, wr, d);
    check("clear_fetch_no_done", 32'(lat), 32'hFFFF_FFFF);
    check("clear_fetch_addr", a_log[4], 32'h102);
    #1 idle(1);

    // clear on the finishing edge
    bus.if_req = 1'b1;
    wait_done(10, 4, 1'b1, -1, lat, wr, d);
    check("clear_last_no_done", 32'(lat), 32'hFFFF_FFFF);
    check("clear_last_addr", a_log[4], 32'h103);
    #1 idle(1);

    // clear in idle delays the grant by one cycle
    bus.if_req = 1'b1;
    wait_done(12, 0, 1'b0, -1, lat, wr, d);
    check("clear_idle_lat", 32'(lat), 32'd6);
    check("clear_idle_data", d, 32'h4433_2211);
    #1 bus.if_req = 1'b0;
    idle(1);

    // clear during a committed word store
    bus.st_req = 1'b1; bus.ls_addr = 32'h300; bus.ls_size = 2'd2; bus.ls_wdata = 32'hDEAD_BEEF;
    wait_done(12, 2, 1'b0, -1, lat, wr, d);
    check("clear_st_lat", 32'(lat), 32'd5);
    check("clear_st_wr_cycles", 32'(wr), 32'd4);
    #1 bus.st_req = 1'b0; bus.clear = 1'b0;
    idle(1);

    // half load wrapping past the top of the address space
    bus.ld_req = 1'b1; bus.ls_addr = 32'hFFFF_FFFF; bus.ls_size = 2'd1;
    wait_done(12, -1, 1'b0, -1, lat, wr, d);
    check("wrap_lat", 32'(lat), 32'd3);
    check("wrap_addr0", a_log[1], 32'hFFFF_FFFF);
    check("wrap_addr1", a_log[2], 32'h0000_0000);
    check("wrap_data", d, 32'h0000_C35A);
    #1 bus.ld_req = 1'b0;
    idle(1);

    // size 3 load stalled for 3 cycles mid-read
    bus.ld_req = 1'b1; bus.ls_addr = 32'h100; bus.ls_size = 2'd3;
    wait_done(16, -1, 1'b0, 2, lat, wr, d);
    check("stall_lat", 32'(lat), 32'd8);
    check("stall_data", d, 32'h4433_2211);
    check("stall_addr_frozen", a_log[5], 32'h101);
    check("stall_addr_resume", a_log[6], 32'h102);
    #1 bus.ld_req = 1'b0; bus.rdy = 1'b1;
    idle(1);

    // reset in the middle of a word store
    bus.st_req = 1'b1; bus.ls_addr = 32'h400; bus.ls_size = 2'd2; bus.ls_wdata = 32'h0102_0304;
    repeat (2) @(negedge clk);
    check("rst_st_active", 32'(bus.mem_wr), 32'd1);
    #1 rst = 1'b1; bus.st_req = 1'b0;
    @(negedge clk);
    check("rst_st_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_st_ls_done", 32'(bus.ls_done), 32'd0);
    #1 rst = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have clock clk and reset rst, synchronous, active-high; all state updates on posedge clk.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- clear  in  1  misprediction flush
- if_req  in  1  fetch wants a 32-bit word; held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  32  fetched word, little-endian
- ld_req  in  1  load request; held until ls_done
- st_req  in  1  committed store request; held until ls_done
- ls_addr  in  32  load/store byte address
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- ls_wdata  in  32  store data; low bytes used
- ls_done  out  1  one-cycle pulse; load or store finished
- ls_rdata  out  32  load bytes, zero-padded above size; extension is done downstream
- mem_din  in  8  RAM read byte; valid one cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe
- io_buffer_full  in  1  UART buffer full

Function
REQ-003 SHALL implement FSM states IDLE, READ and WRITE, with a 2-bit byte counter cnt and a 2-bit byte-count register n (n = bytes - 1).
REQ-004 Grant, evaluated only in IDLE with if_done and ls_done both low:
- st_req wins first, then ld_req, then if_req.
- Exception: if the previous grant was load/store and if_req is high, fetch wins.
REQ-005 A store to 0x30000 or 0x30004 while io_buffer_full=1 SHALL NOT be granted; lower-priority requesters MAY be granted that cycle.
REQ-006 Read grant at edge E0: state<=READ, mem_a<=addr, mem_wr<=0, cnt<=0.
REQ-007 READ, each edge:
- capture mem_din into byte lane cnt of an internal buffer;
- if cnt<n: mem_a<=addr+cnt+1, cnt<=cnt+1;
- else: state<=IDLE and pulse the matching done with the buffer contents.
REQ-008 Read latency: done SHALL be high in the cycle after edge E0+bytes, so a word fetch gives done 4 edges after grant.
REQ-009 Write grant at E0: state<=WRITE, mem_a<=addr, mem_dout<=ls_wdata[7:0], mem_wr<=1, cnt<=0.
REQ-010 WRITE, each edge:
- if cnt<n: drive the next address and byte lane, cnt<=cnt+1;
- else: mem_wr<=0, state<=IDLE, ls_done<=1.
REQ-011 Store occupancy: mem_wr SHALL be high for exactly size bytes consecutive cycles.
REQ-012 Address arithmetic SHALL be 32-bit modulo 2^32; 0xFFFFFFFF+1 wraps to 0.
REQ-013 Done pulses SHALL last exactly one cycle. The next grant SHALL occur no earlier than the edge after the done cycle, giving a minimum one-cycle gap.
REQ-014 clear=1 while in READ: abort immediately, state<=IDLE, and assert no done for that read.
REQ-015 clear=1 while in WRITE: no effect; the committed store SHALL complete and pulse ls_done.
REQ-016 clear=1 in IDLE: no grant that cycle.
REQ-017 clear=1 on the same edge a read would finish: done suppressed.
REQ-018 rdy=0: FSM, counters, buffers and outputs hold their values; a pending done pulse extends until rdy returns.
REQ-019 ls_size=3 SHALL be treated as word.

Reset
REQ-020 rst SHALL dominate rdy and clear, forcing:
- state=IDLE, cnt=0, n=0, last-grant=fetch;
- mem_a=0, mem_dout=0, mem_wr=0;
- if_done=0, ls_done=0, if_data=0, ls_rdata=0.
REQ-021 rst asserted mid-transaction SHALL abandon it; no done pulses after reset and mem_wr=0 from the next cycle.

Verification
REQ-022 Word fetch: if_addr=0x100, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 on successive cycles; if_done high 4 edges after grant with if_data=0x44332211.
REQ-023 Concurrent requests: ld_req (size=1, addr 0x200) and if_req raised together after a fetch -> load granted first, ls_rdata=0x0000BBAA; fetch granted one idle cycle after ls_done.
REQ-024 UART back-pressure: st_req to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0; after release, one mem_wr cycle with mem_a=0x30000, then ls_done.
REQ-025 Clear behaviour: clear during a word fetch at cnt=2 -> no if_done, state IDLE next cycle; clear during a word store -> 4 mem_wr cycles still occur and ls_done pulses.
REQ-026 Address wrap: half load at 0xFFFFFFFF -> second mem_a=0x00000000.
REQ-027 Stall and reset: rdy=0 for 3 cycles mid-read -> mem_a and cnt frozen, and data is correct when resumed; rst mid-store -> mem_wr=0 the next cycle.
